// File: rtl/compute_feed_scheduler.sv
// Batch sequencer feeding one graph-counting compute module: it answers requestGraph
// with tagged graphs after a fixed latency, retires results into a batch sum and tracks completion.
module compute_feed_scheduler #(
  parameter int unsigned EXTRA_DATA_WIDTH = 14,
  parameter int unsigned REQUEST_LATENCY  = 3,
  parameter int unsigned MAX_IN_FLIGHT    = 63,
  parameter int unsigned SUM_WIDTH        = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        batchStart,
  input  logic [127:0]                botIn,
  input  logic                        botValid,
  input  logic                        botLast,
  output logic                        botReady,
  input  logic                        requestGraph,
  output logic [127:0]                botOut,
  output logic                        startOut,
  output logic [EXTRA_DATA_WIDTH-1:0] tagOut,
  input  logic                        done,
  input  logic [5:0]                  resultCount,
  input  logic [EXTRA_DATA_WIDTH-1:0] tagIn,
  output logic                        resultValid,
  output logic [5:0]                  resultCountOut,
  output logic [EXTRA_DATA_WIDTH-1:0] resultTag,
  output logic [SUM_WIDTH-1:0]        batchSum,
  output logic [31:0]                 bubbleCount,
  output logic                        batchDone,
  output logic                        protocolError
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_FINISHED = 2'd3;

  localparam int unsigned IFW = $clog2(MAX_IN_FLIGHT + 1);
  localparam logic [IFW-1:0] MAX_IF = IFW'(MAX_IN_FLIGHT);

  logic [1:0]                  state_q, state_d;
  logic [IFW-1:0]              inflight_q, inflight_d;
  logic [EXTRA_DATA_WIDTH-1:0] tag_q, tag_d;
  logic [EXTRA_DATA_WIDTH-1:0] rtag_q, rtag_d;
  logic [SUM_WIDTH-1:0]        sum_q, sum_d;
  logic [31:0]                 bubble_q, bubble_d;
  logic                        perr_q, perr_d;
  logic                        res_vld_q, res_vld_d;
  logic [5:0]                  res_cnt_q, res_cnt_d;
  logic [EXTRA_DATA_WIDTH-1:0] res_tag_q, res_tag_d;

  logic [REQUEST_LATENCY-1:0]  dl_vld_q;
  logic [127:0]                dl_bot_q [REQUEST_LATENCY];
  logic [EXTRA_DATA_WIDTH-1:0] dl_tag_q [REQUEST_LATENCY];

  logic accept;
  logic start_run;
  logic line_busy;
  logic retire_dec;

  assign botReady = rst & requestGraph & (state_q == S_RUN) & (inflight_q < MAX_IF);

  always_comb begin
    accept     = botValid & botReady;
    start_run  = batchStart & ((state_q == S_IDLE) | (state_q == S_FINISHED));
    line_busy  = |dl_vld_q;
    retire_dec = done & (inflight_q != '0);

    state_d = state_q;
    case (state_q)
      S_IDLE:     if (batchStart) state_d = S_RUN;
      S_RUN:      if (accept && botLast) state_d = S_DRAIN;
      S_DRAIN:    if ((inflight_q == '0) && !line_busy) state_d = S_FINISHED;
      S_FINISHED: if (batchStart) state_d = S_RUN;
      default:    state_d = S_IDLE;
    endcase

    inflight_d = inflight_q;
    if (accept && !retire_dec) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && retire_dec) begin
      inflight_d = inflight_q - 1'b1;
    end

    tag_d = tag_q;
    if (start_run) begin
      tag_d = '0;
    end else if (accept) begin
      tag_d = tag_q + 1'b1;
    end

    bubble_d = bubble_q;
    if (start_run) begin
      bubble_d = '0;
    end else if (requestGraph && !accept && (state_q == S_RUN) && (bubble_q != '1)) begin
      bubble_d = bubble_q + 32'd1;
    end

    // A batchStart coinciding with a result clears the batch rather than folding the result in.
    sum_d  = sum_q;
    rtag_d = rtag_q;
    perr_d = perr_q;
    if (start_run) begin
      sum_d  = '0;
      rtag_d = '0;
      perr_d = 1'b0;
    end else if (done) begin
      sum_d  = sum_q + SUM_WIDTH'(resultCount);
      rtag_d = rtag_q + 1'b1;
      if ((inflight_q == '0) || (tagIn != rtag_q)) begin
        perr_d = 1'b1;
      end
    end

    res_vld_d = done;
    res_cnt_d = done ? resultCount : res_cnt_q;
    res_tag_d = done ? tagIn : res_tag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      inflight_q <= '0;
      tag_q      <= '0;
      rtag_q     <= '0;
      sum_q      <= '0;
      bubble_q   <= '0;
      perr_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_cnt_q  <= '0;
      res_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      rtag_q     <= rtag_d;
      sum_q      <= sum_d;
      bubble_q   <= bubble_d;
      perr_q     <= perr_d;
      res_vld_q  <= res_vld_d;
      res_cnt_q  <= res_cnt_d;
      res_tag_q  <= res_tag_d;
    end
  end

  // Unaccepted request cycles and idle cycles both shift in an all-zero entry, so
  // every slot that is not a real graph presents zeros at the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_vld_q <= '0;
      for (int unsigned i = 0; i < REQUEST_LATENCY; i++) begin
        dl_bot_q[i] <= '0;
        dl_tag_q[i] <= '0;
      end
    end else begin
      dl_vld_q[0] <= accept;
      dl_bot_q[0] <= accept ? botIn : '0;
      dl_tag_q[0] <= accept ? tag_q : '0;
      for (int unsigned i = 1; i < REQUEST_LATENCY; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_bot_q[i] <= dl_bot_q[i-1];
        dl_tag_q[i] <= dl_tag_q[i-1];
      end
    end
  end

  assign startOut       = dl_vld_q[REQUEST_LATENCY-1];
  assign botOut         = dl_bot_q[REQUEST_LATENCY-1];
  assign tagOut         = dl_tag_q[REQUEST_LATENCY-1];
  assign resultValid    = res_vld_q;
  assign resultCountOut = res_cnt_q;
  assign resultTag      = res_tag_q;
  assign batchSum       = sum_q;
  assign bubbleCount    = bubble_q;
  assign batchDone      = (state_q == S_FINISHED);
  assign protocolError  = perr_q;

endmodule

// File: tb/tb_compute_feed_scheduler.sv
// Self-checking bench for compute_feed_scheduler: directed scenarios plus a randomized
// phase, all compared against a cycle-indexed behavioural model of the batch rules.
module tb_compute_feed_scheduler;

  localparam int EDW  = 3;
  localparam int LAT  = 3;
  localparam int MAXF = 5;
  localparam int SW   = 48;

  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_FIN = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           batchStart;
  logic [127:0]   botIn;
  logic           botValid;
  logic           botLast;
  logic           botReady;
  logic           requestGraph;
  logic [127:0]   botOut;
  logic           startOut;
  logic [EDW-1:0] tagOut;
  logic           done;
  logic [5:0]     resultCount;
  logic [EDW-1:0] tagIn;
  logic           resultValid;
  logic [5:0]     resultCountOut;
  logic [EDW-1:0] resultTag;
  logic [SW-1:0]  batchSum;
  logic [31:0]    bubbleCount;
  logic           batchDone;
  logic           protocolError;

  always #5 clk = ~clk;

  compute_feed_scheduler #(
    .EXTRA_DATA_WIDTH(EDW),
    .REQUEST_LATENCY (LAT),
    .MAX_IN_FLIGHT   (MAXF),
    .SUM_WIDTH       (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .batchStart    (batchStart),
    .botIn         (botIn),
    .botValid      (botValid),
    .botLast       (botLast),
    .botReady      (botReady),
    .requestGraph  (requestGraph),
    .botOut        (botOut),
    .startOut      (startOut),
    .tagOut        (tagOut),
    .done          (done),
    .resultCount   (resultCount),
    .tagIn         (tagIn),
    .resultValid   (resultValid),
    .resultCountOut(resultCountOut),
    .resultTag     (resultTag),
    .batchSum      (batchSum),
    .bubbleCount   (bubbleCount),
    .batchDone     (batchDone),
    .protocolError (protocolError)
  );

  int checks = 0;
  int errors = 0;

  // Model: each accepted graph is scheduled for the absolute cycle it must appear.
  typedef struct {
    int           cyc;
    logic [127:0] bot;
    int           tag;
  } pend_t;

  pend_t           sched_q[$];
  int              cyc;
  int              m_phase, m_infl, m_tag, m_rtag, m_rc, m_rt;
  longint unsigned m_sum, m_bub;
  bit              m_perr, m_rv;
  int              seen_tag[$];
  int              seen_cyc[$];
  int              acc_cyc[$];

  localparam longint unsigned SUM_MASK = (64'd1 << SW) - 64'd1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    sched_q.delete();
    m_phase = P_IDLE; m_infl = 0; m_tag = 0; m_rtag = 0; m_rc = 0; m_rt = 0;
    m_sum = 0; m_bub = 0; m_perr = 0; m_rv = 0; cyc = 0;
  endtask

  task automatic chk_zero(input string where);
    chk({where, "_botReady"}, botReady, 0);
    chk({where, "_startOut"}, startOut, 0);
    chk({where, "_botOut"}, botOut, 0);
    chk({where, "_tagOut"}, tagOut, 0);
    chk({where, "_resultValid"}, resultValid, 0);
    chk({where, "_resultCountOut"}, resultCountOut, 0);
    chk({where, "_resultTag"}, resultTag, 0);
    chk({where, "_batchSum"}, batchSum, 0);
    chk({where, "_bubbleCount"}, bubbleCount, 0);
    chk({where, "_batchDone"}, batchDone, 0);
    chk({where, "_protocolError"}, protocolError, 0);
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model, realign after the rising edge.
  task automatic step(input bit bs, input bit bv, input bit bl, input logic [127:0] bot,
                      input bit req, input bit dn, input int cnt, input int tg);
    bit           exp_ready, exp_start, acc, busy, starting;
    logic [127:0] exp_bot;
    int           exp_tag, old_infl;
    batchStart = bs; botValid = bv; botLast = bl; botIn = bot;
    requestGraph = req; done = dn; resultCount = 6'(cnt); tagIn = EDW'(tg);
    @(negedge clk);
    exp_ready = req && (m_phase == P_RUN) && (m_infl < MAXF);
    exp_start = 0; exp_bot = '0; exp_tag = 0;
    if (sched_q.size() > 0 && sched_q[0].cyc == cyc) begin
      exp_start = 1; exp_bot = sched_q[0].bot; exp_tag = sched_q[0].tag;
    end
    chk("botReady", botReady, exp_ready);
    chk("startOut", startOut, exp_start);
    chk("botOut", botOut, exp_bot);
    chk("tagOut", tagOut, exp_tag);
    chk("resultValid", resultValid, m_rv);
    chk("resultCountOut", resultCountOut, m_rc);
    chk("resultTag", resultTag, m_rt);
    chk("batchSum", batchSum, m_sum);
    chk("bubbleCount", bubbleCount, m_bub);
    chk("batchDone", batchDone, m_phase == P_FIN);
    chk("protocolError", protocolError, m_perr);
    if (startOut === 1'b1) begin
      seen_tag.push_back(int'(tagOut));
      seen_cyc.push_back(cyc);
    end

    acc      = bv && exp_ready;
    busy     = sched_q.size() != 0;
    old_infl = m_infl;
    starting = bs && (m_phase == P_IDLE || m_phase == P_FIN);
    if (starting) begin
      m_phase = P_RUN; m_sum = 0; m_bub = 0; m_tag = 0; m_rtag = 0; m_perr = 0;
    end else if (m_phase == P_RUN) begin
      if (req && !acc && m_bub != 64'hFFFF_FFFF) m_bub++;
      if (acc && bl) m_phase = P_DRAIN;
    end else if (m_phase == P_DRAIN) begin
      if (old_infl == 0 && !busy) m_phase = P_FIN;
    end
    if (dn && !starting) begin
      if (old_infl == 0 || tg != m_rtag) m_perr = 1;
      m_rtag = (m_rtag + 1) % (1 << EDW);
      m_sum  = (m_sum + longint'(cnt)) & SUM_MASK;
    end
    m_rv = dn;
    if (dn) begin m_rc = cnt; m_rt = tg; end
    m_infl = old_infl + int'(acc) - int'(dn && old_infl > 0);
    if (busy && sched_q[0].cyc == cyc) void'(sched_q.pop_front());
    if (acc) begin
      sched_q.push_back('{cyc + LAT, bot, m_tag});
      acc_cyc.push_back(cyc);
      m_tag = (m_tag + 1) % (1 << EDW);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rbot();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic beat(input bit last);
    step(0, 1, last, rbot(), 1, 0, 0, 0);
  endtask

  task automatic ret(input int cnt);
    step(0, 0, 0, '0, 0, 1, cnt, m_rtag);
  endtask

  task automatic drain_all();
    for (int k = 0; k < 2 * MAXF && m_infl > 0; k++) ret(int'($urandom_range(0, 63)));
    idle(4);
  endtask

  task automatic clear_seen();
    seen_tag.delete(); seen_cyc.delete(); acc_cyc.delete();
  endtask

  initial begin
    int exp_wrap[10];
    rst = 1'b0; batchStart = 0; botIn = '0; botValid = 0; botLast = 0;
    requestGraph = 0; done = 0; resultCount = '0; tagIn = '0;
    model_reset();

    // Reset state
    #2;
    chk_zero("reset");
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic stream: four beats, counts 1..4
    step(1, 0, 0, '0, 0, 0, 0, 0);
    clear_seen();
    for (int i = 0; i < 4; i++) beat(i == 3);
    idle(4);
    chk("basic_starts", seen_tag.size(), 4);
    for (int i = 0; i < 4 && i < seen_tag.size(); i++) begin
      chk("basic_tag", seen_tag[i], i);
      chk("basic_latency", seen_cyc[i] - acc_cyc[i], LAT);
    end
    for (int i = 1; i <= 4; i++) ret(i);
    idle(3);
    chk("basic_sum", batchSum, 10);
    chk("basic_done", batchDone, 1);

    // Bubbles: valid low on two of five request cycles
    step(1, 0, 0, '0, 0, 0, 0, 0);
    clear_seen();
    beat(0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    beat(0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    beat(1);
    idle(4);
    chk("bubble_count", bubbleCount, 2);
    chk("bubble_starts", seen_tag.size(), 3);
    for (int i = 0; i < 3 && i < seen_cyc.size(); i++)
      chk("bubble_latency", seen_cyc[i] - acc_cyc[i], LAT);
    for (int i = 0; i < 3; i++) ret(5);
    idle(3);
    chk("bubble_done", batchDone, 1);

    // Credit limit
    step(1, 0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < MAXF + 1; i++) beat(0);
    chk("credit_full", botReady, 0);
    step(0, 0, 0, '0, 1, 1, 3, m_rtag);
    chk("credit_restored", botReady, 1);
    beat(0);
    chk("credit_full2", botReady, 0);
    step(0, 0, 0, '0, 1, 1, 3, m_rtag);
    step(0, 1, 0, rbot(), 1, 1, 2, m_rtag);
    chk("credit_acc_done_ready", botReady, 1);
    beat(0);
    chk("credit_acc_done_kept", botReady, 0);
    ret(1);
    beat(1);
    drain_all();
    chk("credit_done", batchDone, 1);
    chk("credit_perr", protocolError, 0);

    // Errors: retire with nothing in flight, then a wrong tag
    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 7, 0);
    chk("err_empty_perr", protocolError, 1);
    chk("err_empty_sum", batchSum, 7);
    beat(1);
    idle(3);
    ret(2);
    idle(3);
    chk("err_sum2", batchSum, 9);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    chk("err_cleared", protocolError, 0);
    beat(1);
    idle(3);
    step(0, 0, 0, '0, 0, 1, 1, 5);
    chk("err_badtag", protocolError, 1);
    idle(3);

    // Tag wrap over ten graphs
    step(1, 0, 0, '0, 0, 0, 0, 0);
    clear_seen();
    for (int i = 0; i < 5; i++) beat(0);
    idle(3);
    for (int i = 0; i < 5; i++) ret(1);
    for (int i = 0; i < 5; i++) beat(i == 4);
    idle(3);
    for (int i = 0; i < 5; i++) ret(1);
    idle(3);
    for (int i = 0; i < 10; i++) exp_wrap[i] = i % 8;
    chk("wrap_starts", seen_tag.size(), 10);
    for (int i = 0; i < 10 && i < seen_tag.size(); i++) chk("wrap_tag", seen_tag[i], exp_wrap[i]);
    chk("wrap_perr", protocolError, 0);
    chk("wrap_done", batchDone, 1);
    chk("wrap_sum", batchSum, 10);

    // Reset one cycle after an accept
    step(1, 0, 0, '0, 0, 0, 0, 0);
    beat(0);
    batchStart = 0; botValid = 1; requestGraph = 1; done = 0;
    #2 rst = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    chk("midreset_start_a", startOut, 0);
    @(posedge clk);
    #1;
    chk_zero("midreset_held");
    botValid = 0; requestGraph = 0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    clear_seen();
    idle(6);
    chk("midreset_nostart", seen_tag.size(), 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    beat(1);
    idle(3);
    chk("resume_tag", seen_tag.size() > 0 ? seen_tag[0] : -1, 0);
    ret(9);
    idle(3);
    chk("resume_sum", batchSum, 9);
    chk("resume_done", batchDone, 1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      bit bs, bv, bl, req, dn;
      int tg;
      bs  = ($urandom_range(0, 19) == 0);
      bv  = ($urandom_range(0, 9) < 7);
      req = ($urandom_range(0, 9) < 7);
      bl  = ($urandom_range(0, 9) == 0);
      dn  = (m_infl > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
      if (bs) dn = 0;
      tg  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 7)) : m_rtag;
      step(bs, bv, bl, rbot(), req, dn, int'($urandom_range(0, 63)), tg);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
